// File: rtl/pyrm_regfile_wb_receiver_pkg.sv
// Shared widths and the pending-write entry type for the write-back receiver.
package pyrm_regfile_wb_receiver_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;

    // One pending register write: destination index and payload.
    typedef struct packed {
        reg_idx_t idx;
        xdata_t   data;
    } wb_entry_t;

    // True when the upper address bits carry anything beyond the register index.
    function automatic logic addr_out_of_range(input logic [XLEN-1:0] addr);
        return |addr[XLEN-1:REG_IDX_W];
    endfunction

endpackage

// File: rtl/pyrm_wb_fifo.sv
// Pending-write FIFO: DEPTH entries of {idx, data}.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   push, push_entry   enqueue request and payload (ignored when full)
//   pop             dequeue request (ignored when empty)
//   head            oldest entry
//   count           number of valid entries
//   full, empty     status from the registered count
//   age_entries     entries ordered oldest (index 0) to youngest
//   age_valid       which of age_entries hold live data
module pyrm_wb_fifo
    import pyrm_regfile_wb_receiver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output wb_entry_t [DEPTH-1:0]        age_entries,
    output logic [DEPTH-1:0]             age_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the count unchanged.
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Rotate storage into age order so the bypass search can pick the
    // youngest match by position alone. Pointer arithmetic wraps because
    // DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entries[i] = mem[rd_ptr + PW'(i)];
            age_valid[i]   = (CW'(i) < count);
        end
    end

endmodule

// File: rtl/pyrm_regfile_wb_receiver.sv
// Decode-side write-back receiver: joins the addr/data result channels,
// buffers accepted writes in a FIFO, drains them into the 32x64 register
// file one per cycle and serves two combinational read ports with bypass
// from pending FIFO entries.
// Ports:
//   clk, reset_pyri                    clock, synchronous active-high reset
//   reg_addr_* / reg_data_*            write-back channels (valid/retry)
//   dbg_wr_*                           debug write, always accepted, owns the write port
//   rs1_* / rs2_*                      combinational read ports
//   pending_pyro                       FIFO non-empty
//   addr_err_pyro                      sticky: an accepted addr had bits above the index set
module pyrm_regfile_wb_receiver
    import pyrm_regfile_wb_receiver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_pyri,
    input  logic [XLEN-1:0]      reg_addr_pyri,
    input  logic                 reg_addr_valid_pyri,
    output logic                 reg_addr_retry_pyro,
    input  logic [XLEN-1:0]      reg_data_pyri,
    input  logic                 reg_data_valid_pyri,
    output logic                 reg_data_retry_pyro,
    input  logic [REG_IDX_W-1:0] dbg_wr_addr_pyri,
    input  logic [XLEN-1:0]      dbg_wr_data_pyri,
    input  logic                 dbg_wr_valid_pyri,
    input  logic [REG_IDX_W-1:0] rs1_addr_pyri,
    output logic [XLEN-1:0]      rs1_data_pyro,
    input  logic [REG_IDX_W-1:0] rs2_addr_pyri,
    output logic [XLEN-1:0]      rs2_data_pyro,
    output logic                 pending_pyro,
    output logic                 addr_err_pyro
);

    xdata_t                regs [NREG];
    logic                  accept;
    logic                  push;
    logic                  pop;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic [$clog2(DEPTH):0] count;
    logic                  full;
    logic                  empty;
    wb_entry_t [DEPTH-1:0] age_entries;
    logic [DEPTH-1:0]      age_valid;

    // Join: both channels move together. Full comes from the registered
    // count, so a dequeue in the same cycle does not open a slot early.
    assign accept              = reg_addr_valid_pyri && reg_data_valid_pyri && !full && !reset_pyri;
    assign reg_addr_retry_pyro = !accept;
    assign reg_data_retry_pyro = !accept;

    assign push_entry.idx  = reg_addr_pyri[REG_IDX_W-1:0];
    assign push_entry.data = reg_data_pyri;
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push            = accept && (push_entry.idx != '0);
    // The debug write owns the regfile port; the FIFO waits.
    assign pop             = !empty && !dbg_wr_valid_pyri && !reset_pyri;
    assign pending_pyro    = !empty;

    pyrm_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset_pyri),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .age_entries (age_entries),
        .age_valid   (age_valid)
    );

    always_ff @(posedge clk) begin
        if (reset_pyri) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            addr_err_pyro <= 1'b0;
        end else begin
            if (dbg_wr_valid_pyri) begin
                if (dbg_wr_addr_pyri != '0) begin
                    regs[dbg_wr_addr_pyri] <= dbg_wr_data_pyri;
                end
            end else if (pop) begin
                regs[head.idx] <= head.data;
            end
            if (accept && addr_out_of_range(reg_addr_pyri)) begin
                addr_err_pyro <= 1'b1;
            end
        end
    end

    // Youngest matching pending entry wins: later (younger) positions in
    // age order override earlier ones.
    function automatic xdata_t bypass_read(
        input reg_idx_t              a,
        input xdata_t                rf_val,
        input wb_entry_t [DEPTH-1:0] e,
        input logic [DEPTH-1:0]      v
    );
        xdata_t d;
        d = rf_val;
        for (int i = 0; i < DEPTH; i++) begin
            if (v[i] && (e[i].idx == a)) begin
                d = e[i].data;
            end
        end
        if (a == '0) begin
            d = '0;
        end
        return d;
    endfunction

    assign rs1_data_pyro = bypass_read(rs1_addr_pyri, regs[rs1_addr_pyri], age_entries, age_valid);
    assign rs2_data_pyro = bypass_read(rs2_addr_pyri, regs[rs2_addr_pyri], age_entries, age_valid);

endmodule

// File: tb/tb_pyrm_regfile_wb_receiver.sv
module tb_pyrm_regfile_wb_receiver;

    logic        clk = 1'b0;
    logic        reset_pyri;
    logic [63:0] reg_addr_pyri;
    logic        reg_addr_valid_pyri;
    logic        reg_addr_retry_pyro;
    logic [63:0] reg_data_pyri;
    logic        reg_data_valid_pyri;
    logic        reg_data_retry_pyro;
    logic [4:0]  dbg_wr_addr_pyri;
    logic [63:0] dbg_wr_data_pyri;
    logic        dbg_wr_valid_pyri;
    logic [4:0]  rs1_addr_pyri;
    logic [63:0] rs1_data_pyro;
    logic [4:0]  rs2_addr_pyri;
    logic [63:0] rs2_data_pyro;
    logic        pending_pyro;
    logic        addr_err_pyro;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pyrm_regfile_wb_receiver dut (
        .clk                 (clk),
        .reset_pyri          (reset_pyri),
        .reg_addr_pyri       (reg_addr_pyri),
        .reg_addr_valid_pyri (reg_addr_valid_pyri),
        .reg_addr_retry_pyro (reg_addr_retry_pyro),
        .reg_data_pyri       (reg_data_pyri),
        .reg_data_valid_pyri (reg_data_valid_pyri),
        .reg_data_retry_pyro (reg_data_retry_pyro),
        .dbg_wr_addr_pyri    (dbg_wr_addr_pyri),
        .dbg_wr_data_pyri    (dbg_wr_data_pyri),
        .dbg_wr_valid_pyri   (dbg_wr_valid_pyri),
        .rs1_addr_pyri       (rs1_addr_pyri),
        .rs1_data_pyro       (rs1_data_pyro),
        .rs2_addr_pyri       (rs2_addr_pyri),
        .rs2_data_pyro       (rs2_data_pyro),
        .pending_pyro        (pending_pyro),
        .addr_err_pyro       (addr_err_pyro)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic av, input logic dv, input logic [63:0] a, input logic [63:0] d);
        reg_addr_valid_pyri = av;
        reg_data_valid_pyri = dv;
        reg_addr_pyri       = a;
        reg_data_pyri       = d;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset_pyri        = 1'b1;
        drive_wb(1'b1, 1'b1, 64'd9, 64'h99);
        dbg_wr_addr_pyri  = '0;
        dbg_wr_data_pyri  = '0;
        dbg_wr_valid_pyri = 1'b0;
        rs1_addr_pyri     = 5'd5;
        rs2_addr_pyri     = 5'd9;

        // ---- reset ----
        tick();
        settle();
        chk("rst_addr_retry", reg_addr_retry_pyro, 1);
        chk("rst_data_retry", reg_data_retry_pyro, 1);
        chk("rst_pending", pending_pyro, 0);
        chk("rst_err", addr_err_pyro, 0);
        chk("rst_rs1", rs1_data_pyro, 0);
        tick();
        reset_pyri = 1'b0;
        drive_wb(1'b0, 1'b0, 0, 0);
        settle();
        chk("rst_rs2_after", rs2_data_pyro, 0);

        // ---- join: addr held 3 cycles before data ----
        drive_wb(1'b1, 1'b0, 64'd5, 64'h0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("join_addr_retry", reg_addr_retry_pyro, 1);
            chk("join_data_retry", reg_data_retry_pyro, 1);
            tick();
        end
        drive_wb(1'b1, 1'b1, 64'd5, 64'hDEAD);
        settle();
        chk("join_accept_addr", reg_addr_retry_pyro, 0);
        chk("join_accept_data", reg_data_retry_pyro, 0);
        chk("join_no_same_cycle_bypass", rs1_data_pyro, 0);
        tick();
        drive_wb(1'b0, 1'b0, 0, 0);
        settle();
        chk("join_pending", pending_pyro, 1);
        chk("join_bypass", rs1_data_pyro, 64'hDEAD);
        tick();
        settle();
        chk("join_drained", pending_pyro, 0);
        chk("join_rf", rs1_data_pyro, 64'hDEAD);

        // ---- full: 4 accepts under a debug stall (dbg to x0 is a no-op) ----
        dbg_wr_valid_pyri = 1'b1;
        dbg_wr_addr_pyri  = 5'd0;
        dbg_wr_data_pyri  = 64'hBAD;
        for (int i = 11; i <= 14; i++) begin
            drive_wb(1'b1, 1'b1, 64'(i), 64'h100 + 64'(i));
            settle();
            chk("full_acc_retry", reg_addr_retry_pyro, 0);
            tick();
        end
        drive_wb(1'b1, 1'b1, 64'd15, 64'h10F);
        settle();
        chk("full_5th_addr_retry", reg_addr_retry_pyro, 1);
        chk("full_5th_data_retry", reg_data_retry_pyro, 1);
        rs1_addr_pyri = 5'd12;
        rs2_addr_pyri = 5'd14;
        settle();
        chk("full_byp_rs1", rs1_data_pyro, 64'h10C);
        chk("full_byp_rs2", rs2_data_pyro, 64'h10E);
        // Full is registered: retry holds in the cycle the first pop happens.
        dbg_wr_valid_pyri = 1'b0;
        settle();
        chk("full_no_passthru", reg_addr_retry_pyro, 1);
        tick();
        drive_wb(1'b1, 1'b1, 64'd0, 64'h55);
        settle();
        chk("full_slot_opened", reg_addr_retry_pyro, 0);
        tick();
        drive_wb(1'b0, 1'b0, 0, 0);
        tick();
        settle();
        chk("full_pending_last", pending_pyro, 1);
        tick();
        settle();
        chk("full_empty", pending_pyro, 0);
        chk("full_rf_12", rs1_data_pyro, 64'h10C);
        chk("full_rf_14", rs2_data_pyro, 64'h10E);
        rs1_addr_pyri = 5'd0;
        settle();
        chk("full_x0_discard", rs1_data_pyro, 0);

        // ---- bypass order: x7=1 then x7=2 behind a dbg stall ----
        dbg_wr_valid_pyri = 1'b1;
        dbg_wr_addr_pyri  = 5'd3;
        dbg_wr_data_pyri  = 64'h33;
        rs1_addr_pyri     = 5'd3;
        rs2_addr_pyri     = 5'd7;
        drive_wb(1'b1, 1'b1, 64'd7, 64'd1);
        settle();
        chk("byp_dbg_not_bypassed", rs1_data_pyro, 0);
        chk("byp_acc_not_bypassed", rs2_data_pyro, 0);
        tick();
        dbg_wr_addr_pyri = 5'd0;
        drive_wb(1'b1, 1'b1, 64'd7, 64'd2);
        settle();
        chk("byp_dbg_visible", rs1_data_pyro, 64'h33);
        chk("byp_first", rs2_data_pyro, 64'd1);
        tick();
        drive_wb(1'b0, 1'b0, 0, 0);
        settle();
        chk("byp_youngest", rs2_data_pyro, 64'd2);
        dbg_wr_valid_pyri = 1'b0;
        tick();
        settle();
        chk("byp_youngest_over_rf", rs2_data_pyro, 64'd2);
        tick();
        settle();
        chk("byp_drained", pending_pyro, 0);
        chk("byp_rf_final", rs2_data_pyro, 64'd2);

        // ---- x0 with upper bits set ----
        chk("err_before", addr_err_pyro, 0);
        drive_wb(1'b1, 1'b1, 64'h20, 64'hFF);
        settle();
        chk("err_accept", reg_data_retry_pyro, 0);
        tick();
        drive_wb(1'b0, 1'b0, 0, 0);
        rs1_addr_pyri = 5'd0;
        settle();
        chk("err_sticky", addr_err_pyro, 1);
        chk("err_not_pushed", pending_pyro, 0);
        chk("err_x0_read", rs1_data_pyro, 0);
        tick();
        settle();
        chk("err_still_sticky", addr_err_pyro, 1);

        // ---- reset mid-drain ----
        dbg_wr_valid_pyri = 1'b1;
        dbg_wr_addr_pyri  = 5'd0;
        for (int i = 20; i <= 22; i++) begin
            drive_wb(1'b1, 1'b1, 64'(i), 64'hA0 + 64'(i));
            tick();
        end
        dbg_wr_valid_pyri = 1'b0;
        drive_wb(1'b1, 1'b1, 64'd23, 64'hB7);
        settle();
        chk("mid_pending", pending_pyro, 1);
        reset_pyri = 1'b1;
        settle();
        chk("mid_rst_retry_a", reg_addr_retry_pyro, 1);
        chk("mid_rst_retry_d", reg_data_retry_pyro, 1);
        tick();
        reset_pyri = 1'b0;
        drive_wb(1'b0, 1'b0, 0, 0);
        rs1_addr_pyri = 5'd20;
        rs2_addr_pyri = 5'd22;
        settle();
        chk("mid_pending_clr", pending_pyro, 0);
        chk("mid_rs1_20", rs1_data_pyro, 0);
        chk("mid_rs2_22", rs2_data_pyro, 0);
        chk("mid_err_clr", addr_err_pyro, 0);
        rs1_addr_pyri = 5'd7;
        rs2_addr_pyri = 5'd23;
        settle();
        chk("mid_rf_cleared", rs1_data_pyro, 0);
        chk("mid_no_accept", rs2_data_pyro, 0);

        // ---- wrap: 10 back-to-back writes ----
        for (int i = 1; i <= 10; i++) begin
            drive_wb(1'b1, 1'b1, 64'(i), 64'(i * 3));
            settle();
            chk("wrap_no_retry", reg_addr_retry_pyro, 0);
            tick();
        end
        drive_wb(1'b0, 1'b0, 0, 0);
        tick();
        settle();
        chk("wrap_drained", pending_pyro, 0);
        for (int i = 1; i <= 10; i++) begin
            rs1_addr_pyri = 5'(i);
            rs2_addr_pyri = 5'(11 - i);
            settle();
            chk("wrap_rs1", rs1_data_pyro, 64'(i * 3));
            chk("wrap_rs2", rs2_data_pyro, 64'((11 - i) * 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so a wedged run still reports.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
